// File: rtl/voice_phase_scanner_pkg.sv
// Shared encodings for the voice phase scanner: note status values, default
// widths and the scan FSM state type.
package voice_phase_scanner_pkg;

    localparam int PHASE_W_DEF = 32;
    localparam int VEL_W       = 7;

    localparam logic NOTE_ON  = 1'b1;
    localparam logic NOTE_OFF = 1'b0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_t;

endpackage

// File: rtl/voice_state_bank.sv
// Per-voice gate/tuning/velocity/phase storage with one event write port and
// one scan read/accumulate port; the event write wins on a same-slot collision.
module voice_state_bank
    import voice_phase_scanner_pkg::*;
#(
    parameter int NUM_VOICES = 16,
    parameter int VOICE_W    = 4,
    parameter int PHASE_W    = PHASE_W_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  wr_en,
    input  logic                  wr_note,
    input  logic [VOICE_W-1:0]    wr_idx,
    input  logic [PHASE_W-1:0]    wr_tuning,
    input  logic [VEL_W-1:0]      wr_velocity,
    input  logic                  rd_en,
    input  logic [VOICE_W-1:0]    rd_idx,
    output logic                  rd_gate,
    output logic [PHASE_W-1:0]    rd_phase,
    output logic [VEL_W-1:0]      rd_velocity,
    output logic [NUM_VOICES-1:0] gate_vec
);

    logic [NUM_VOICES-1:0] gate_q;
    logic [PHASE_W-1:0]    phase_q  [NUM_VOICES];
    logic [PHASE_W-1:0]    tuning_q [NUM_VOICES];
    logic [VEL_W-1:0]      vel_q    [NUM_VOICES];

    // Read side reflects pre-event state; rd_phase is the post-accumulate value.
    assign rd_gate     = gate_q[rd_idx];
    assign rd_velocity = vel_q[rd_idx];
    assign rd_phase    = gate_q[rd_idx] ? phase_q[rd_idx] + tuning_q[rd_idx]
                                        : phase_q[rd_idx];
    assign gate_vec    = gate_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            gate_q <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase_q[i]  <= '0;
                tuning_q[i] <= '0;
                vel_q[i]    <= '0;
            end
        end else begin
            if (rd_en)
                phase_q[rd_idx] <= rd_phase;
            // Placed after the accumulate so an event to the scanned slot overrides it.
            if (wr_en) begin
                if (wr_note == NOTE_ON) begin
                    gate_q[wr_idx]   <= 1'b1;
                    tuning_q[wr_idx] <= wr_tuning;
                    vel_q[wr_idx]    <= wr_velocity;
                    phase_q[wr_idx]  <= '0;
                end else begin
                    gate_q[wr_idx]   <= 1'b0;
                    vel_q[wr_idx]    <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/voice_phase_scanner.sv
// Scans every voice slot once per sample tick, advancing gated phases and
// presenting the per-slot stream one cycle after each slot is read.
module voice_phase_scanner
    import voice_phase_scanner_pkg::*;
#(
    parameter int NUM_VOICES = 16,
    parameter int VOICE_W    = 4,
    parameter int PHASE_W    = PHASE_W_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_SPI_flag,
    input  logic                 i_SPI_note_status,
    input  logic [7:0]           i_SPI_voice_index,
    input  logic [PHASE_W-1:0]   i_SPI_tuning_code,
    input  logic [VEL_W-1:0]     i_SPI_velocity,
    input  logic                 i_sample_tick,
    output logic                 o_voice_valid,
    output logic [VOICE_W-1:0]   o_voice_index,
    output logic [PHASE_W-1:0]   o_voice_phase,
    output logic [VEL_W-1:0]     o_voice_velocity,
    output logic                 o_voice_gate,
    output logic                 o_frame_done,
    output logic                 o_overrun,
    output logic                 o_bad_index,
    output logic [VOICE_W:0]     o_active_count
);

    scan_state_t           state_q, state_d;
    logic [VOICE_W-1:0]    idx_q, idx_d;
    logic                  scanning, last_slot, bad_idx, ev_en;
    logic                  rd_gate;
    logic [PHASE_W-1:0]    rd_phase;
    logic [VEL_W-1:0]      rd_velocity;
    logic [NUM_VOICES-1:0] gate_vec;
    logic [VOICE_W:0]      popcount;

    logic                  vld_p1, frame_done_p1, overrun_p1, bad_p1, gate_p1;
    logic [VOICE_W-1:0]    index_p1;
    logic [PHASE_W-1:0]    phase_p1;
    logic [VEL_W-1:0]      vel_p1;
    logic [VOICE_W:0]      count_p1;

    assign scanning  = (state_q == ST_SCAN);
    assign last_slot = (idx_q == VOICE_W'(NUM_VOICES - 1));
    // Full 8-bit index is range-checked so out-of-range events never alias a slot.
    assign bad_idx   = i_SPI_flag && (32'(i_SPI_voice_index) >= 32'(NUM_VOICES));
    assign ev_en     = i_SPI_flag && !bad_idx;

    voice_state_bank #(
        .NUM_VOICES (NUM_VOICES),
        .VOICE_W    (VOICE_W),
        .PHASE_W    (PHASE_W)
    ) u_bank (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .wr_en       (ev_en),
        .wr_note     (i_SPI_note_status),
        .wr_idx      (i_SPI_voice_index[VOICE_W-1:0]),
        .wr_tuning   (i_SPI_tuning_code),
        .wr_velocity (i_SPI_velocity),
        .rd_en       (scanning),
        .rd_idx      (idx_q),
        .rd_gate     (rd_gate),
        .rd_phase    (rd_phase),
        .rd_velocity (rd_velocity),
        .gate_vec    (gate_vec)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (i_sample_tick) begin
                    state_d = ST_SCAN;
                    idx_d   = '0;
                end
            end
            ST_SCAN: begin
                idx_d = idx_q + 1'b1;
                if (last_slot)
                    state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        popcount = '0;
        for (int i = 0; i < NUM_VOICES; i++)
            popcount = popcount + {{VOICE_W{1'b0}}, gate_vec[i]};
    end

    // Stage p1: registered slot stream, status pulses and active count
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            vld_p1        <= 1'b0;
            frame_done_p1 <= 1'b0;
            overrun_p1    <= 1'b0;
            bad_p1        <= 1'b0;
            gate_p1       <= 1'b0;
            index_p1      <= '0;
            phase_p1      <= '0;
            vel_p1        <= '0;
            count_p1      <= '0;
        end else begin
            vld_p1        <= scanning;
            frame_done_p1 <= scanning && last_slot;
            overrun_p1    <= scanning && i_sample_tick;
            bad_p1        <= bad_idx;
            count_p1      <= popcount;
            if (scanning) begin
                index_p1 <= idx_q;
                phase_p1 <= rd_phase;
                vel_p1   <= rd_velocity;
                gate_p1  <= rd_gate;
            end
        end
    end

    assign o_voice_valid    = vld_p1;
    assign o_voice_index    = index_p1;
    assign o_voice_phase    = phase_p1;
    assign o_voice_velocity = vel_p1;
    assign o_voice_gate     = gate_p1;
    assign o_frame_done     = frame_done_p1;
    assign o_overrun        = overrun_p1;
    assign o_bad_index      = bad_p1;
    assign o_active_count   = count_p1;

endmodule

// File: doc/voice_phase_scanner.md
Name: voice_phase_scanner

Overview:
Downstream consumer of the SPI command decoder's strobed note events (note status, voice index, tuning code, velocity, flag). Holds per-voice state: gate, tuning code, velocity and a 32-bit phase accumulator. On every audio sample tick it scans all voices in time-multiplexed order and advances each gated voice's phase by its tuning code. The resulting per-voice stream (phase, velocity, gate) feeds the waveform/mixer stage.

Parameters:
NUM_VOICES, 16, number of voice slots (power of two, 2..64)
VOICE_W, 4, log2(NUM_VOICES), voice index width
PHASE_W, 32, phase accumulator and tuning code width

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous active-high reset
i_SPI_flag  in  1  one-cycle strobe, event fields valid
i_SPI_note_status  in  1  1 = note-on, 0 = note-off
i_SPI_voice_index  in  8  target voice slot
i_SPI_tuning_code  in  32  phase increment per sample
i_SPI_velocity  in  7  note velocity
i_sample_tick  in  1  one-cycle pulse per audio sample
o_voice_valid  out  1  output slot fields valid this cycle
o_voice_index  out  VOICE_W  slot being presented
o_voice_phase  out  PHASE_W  updated phase of that slot
o_voice_velocity  out  7  velocity of that slot
o_voice_gate  out  1  gate of that slot
o_frame_done  out  1  pulse with the last slot of a scan
o_overrun  out  1  pulse: tick arrived while scanning
o_bad_index  out  1  pulse: event index >= NUM_VOICES, dropped
o_active_count  out  VOICE_W+1  number of gated voices

Behaviour:
- Reset (async, i_reset=1): all gates 0, phases 0, tunings 0, velocities 0; FSM in IDLE; scan index 0. All outputs 0.
- FSM states IDLE, SCAN.
  - IDLE: i_sample_tick=1 -> SCAN with scan index 0.
  - SCAN: each cycle reads slot[idx], idx increments; after idx = NUM_VOICES-1 -> IDLE. A scan always takes exactly NUM_VOICES cycles.
- Per scanned slot: if gate=1, phase <= phase + tuning (mod 2^PHASE_W, carry discarded); else phase held.
- Output latency: 1 cycle. The fields for slot k (post-update phase) are registered and presented with o_voice_valid=1 in the cycle after slot k is read. o_frame_done=1 coincides with o_voice_valid for slot NUM_VOICES-1. o_voice_valid=0 in all other cycles; data outputs hold their last values.
- Tick while in SCAN: ignored (no restart, no queuing); o_overrun pulses 1 cycle later. Tick in the same cycle SCAN->IDLE is also an overrun. A tick in the first IDLE cycle starts a scan, so back-to-back frames have a 1-cycle gap minimum.
- Event handling (i_SPI_flag=1), registered next cycle:
  - index >= NUM_VOICES: dropped, o_bad_index pulses 1 cycle later. Upper index bits are checked, never truncated.
  - note-on: gate<=1, tuning<=i_SPI_tuning_code, velocity<=i_SPI_velocity, phase<=0. Note-on to an already gated slot retriggers: same writes, count unchanged.
  - note-off: gate<=0, velocity<=0; tuning and phase held; incoming tuning/velocity ignored. Note-off to an ungated slot changes nothing.
- Collision (event targets the slot being scanned in the same cycle): the event's writes win for stored state, including the phase clear over the accumulate. The presented output for that slot shows the pre-event values (old gate, old phase + old tuning if gated).
- o_active_count: registered popcount of gates, updated in the cycle after any gate change; never exceeds NUM_VOICES.
- Events are accepted every cycle in either FSM state. No backpressure; the decoder's strobe is at most one event per cycle.

Decomposition:
- Shared package: NOTE_ON/NOTE_OFF status encodings, PHASE_W, velocity width (7), FSM state encoding.
- One natural sub-module, voice_state_bank: per-slot register arrays, write port (event) and read/accumulate port (scan), with event-priority on collision. The top holds the FSM, output registers and pulses.

Test Plan:
- Reset mid-scan (assert i_reset at slot 5) -> all outputs 0 immediately, FSM IDLE, every slot gate=0 and phase=0.
- Note-on voice 3, tuning 0x0100_0000, vel 100; three ticks -> slot 3 phase 0x0100_0000, 0x0200_0000, 0x0300_0000 with gate=1 and vel=100. Other slots' phase stays 0, gate 0. o_active_count=1.
- Tuning 0xC000_0000 on voice 0, two ticks -> phase 0xC000_0000 then 0x8000_0000 (wrap). Then note-off -> next scan phase held at 0x8000_0000, gate 0, vel 0, count 0.
- Event index 20 with NUM_VOICES=16 -> o_bad_index pulses 1 cycle; no slot changes; count unchanged.
- Tick at scan cycle 7 -> o_overrun pulses once; exactly 16 valid outputs; o_frame_done only on slot 15.
- Note-on to voice 4 in the same cycle slot 4 is scanned (prior phase 0x10, tuning 0x10) -> presented phase 0x20. The stored phase is 0; the next scan shows the new tuning.
